// File: rtl/ltc2308_spi_ctrl.sv
// ---------------------------------------------------------------------------
// ltc2308_spi_ctrl
//
// Serial front-end for the LTC2308 8-channel 12-bit ADC. Each accepted start
// request runs one conversion frame:
//   CONV  : CONVST high for CONV_CYCLES clocks
//   SHIFT : 12 SCK periods (SCK_HALF low, SCK_HALF high, starting low);
//           SDO is shifted in MSB first on the rising SCK edge, SDI carries
//           the 6-bit config word for the *next* conversion, advancing on
//           the falling SCK edge
//   ACQ   : SCK/CONVST held low for ACQ_CYCLES clocks, then back to IDLE
// The LTC2308 pipelines its config by one frame, so the word read during a
// frame belongs to the channel programmed in the previous frame. The first
// frame after reset therefore produces no data_valid.
//
// Ports:
//   clk, reset_n          50 MHz system clock, asynchronous active-low reset
//   start                 frame request, accepted only while busy = 0
//   ch[2:0], uni          channel / unipolar select, sampled with start
//   busy                  high from the cycle after acceptance to frame end
//   data_valid            one-cycle pulse, data/data_ch valid
//   data[11:0], data_ch   last valid result and the channel it came from
//   adc_convst, adc_sck,
//   adc_sdi, adc_sdo      LTC2308 serial pins
// ---------------------------------------------------------------------------
module ltc2308_spi_ctrl #(
    parameter int unsigned CONV_CYCLES = 80,
    parameter int unsigned SCK_HALF    = 2,
    parameter int unsigned ACQ_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  ch,
    input  logic        uni,
    output logic        busy,
    output logic        data_valid,
    output logic [11:0] data,
    output logic [2:0]  data_ch,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    // One shared down-phase counter serves CONV, each SCK half-period and ACQ,
    // so it is sized for the largest of the three intervals.
    localparam int unsigned CNT_M1  = (CONV_CYCLES > ACQ_CYCLES) ? CONV_CYCLES : ACQ_CYCLES;
    localparam int unsigned CNT_MAX = (CNT_M1 > SCK_HALF) ? CNT_M1 : SCK_HALF;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCK_HALF - 1);
    localparam logic [CNT_W-1:0] ACQ_LAST  = CNT_W'(ACQ_CYCLES - 1);

    localparam logic [3:0] LAST_SCK = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SHIFT,
        ST_ACQ
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [5:0]       cfg_q, cfg_d;
    logic [2:0]       ch_q, ch_d;
    logic [2:0]       prev_ch_q, prev_ch_d;
    logic             cfg_known_q, cfg_known_d;
    logic [11:0]      rx_q, rx_d;
    logic             busy_q, busy_d;
    logic             data_valid_q, data_valid_d;
    logic [11:0]      data_q, data_d;
    logic [2:0]       data_ch_q, data_ch_d;
    logic             convst_q, convst_d;
    logic             sck_q, sck_d;
    logic             sdi_q, sdi_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        cfg_d        = cfg_q;
        ch_d         = ch_q;
        prev_ch_d    = prev_ch_q;
        cfg_known_d  = cfg_known_q;
        rx_d         = rx_q;
        busy_d       = busy_q;
        data_valid_d = 1'b0;
        data_d       = data_q;
        data_ch_d    = data_ch_q;
        convst_d     = convst_q;
        sck_d        = sck_q;
        sdi_d        = sdi_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // {S/D, O/S, S1, S0, UNI, SLP}: single-ended, never sleep
                    cfg_d    = {1'b1, ch[0], ch[2], ch[1], uni, 1'b0};
                    ch_d     = ch;
                    state_d  = ST_CONV;
                    busy_d   = 1'b1;
                    convst_d = 1'b1;
                    cnt_d    = '0;
                end
            end

            ST_CONV: begin
                if (cnt_q == CONV_LAST) begin
                    convst_d = 1'b0;
                    sck_d    = 1'b0;
                    sdi_d    = cfg_q[5];
                    cnt_d    = '0;
                    bit_d    = '0;
                    state_d  = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[10:0], adc_sdo};
                    end else begin
                        sck_d = 1'b0;
                        // Config shifts out with zero fill, so SDI is 0 once
                        // all six bits have gone.
                        cfg_d = {cfg_q[4:0], 1'b0};
                        sdi_d = cfg_q[4];
                        if (bit_q == LAST_SCK) begin
                            state_d = ST_ACQ;
                            // Result belongs to the channel set up in the
                            // previous frame; unknown after reset.
                            if (cfg_known_q) begin
                                data_valid_d = 1'b1;
                                data_d       = rx_q;
                                data_ch_d    = prev_ch_q;
                            end
                            prev_ch_d   = ch_q;
                            cfg_known_d = 1'b1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_ACQ: begin
                if (cnt_q == ACQ_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            cfg_q        <= '0;
            ch_q         <= '0;
            prev_ch_q    <= '0;
            cfg_known_q  <= 1'b0;
            rx_q         <= '0;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            data_ch_q    <= '0;
            convst_q     <= 1'b0;
            sck_q        <= 1'b0;
            sdi_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            cfg_q        <= cfg_d;
            ch_q         <= ch_d;
            prev_ch_q    <= prev_ch_d;
            cfg_known_q  <= cfg_known_d;
            rx_q         <= rx_d;
            busy_q       <= busy_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            data_ch_q    <= data_ch_d;
            convst_q     <= convst_d;
            sck_q        <= sck_d;
            sdi_q        <= sdi_d;
        end
    end

    assign busy       = busy_q;
    assign data_valid = data_valid_q;
    assign data       = data_q;
    assign data_ch    = data_ch_q;
    assign adc_convst = convst_q;
    assign adc_sck    = sck_q;
    assign adc_sdi    = sdi_q;

endmodule

// File: tb/tb_ltc2308_spi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ltc2308_spi_ctrl
//
// Bench for ltc2308_spi_ctrl at default parameters. An LTC2308 SDO model
// presents a per-frame 12-bit word MSB first, moving to the next bit on each
// SCK falling edge after CONVST. A frame-level reference model tracks the
// one-frame config pipeline (known flag, previous channel, held data).
// ---------------------------------------------------------------------------
module tb_ltc2308_spi_ctrl;

    localparam int CONV     = 80;
    localparam int HALF     = 2;
    localparam int ACQ      = 12;
    localparam int BUSY_LEN = CONV + 24 * HALF + ACQ;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  ch;
    logic        uni;
    logic        busy;
    logic        data_valid;
    logic [11:0] data;
    logic [2:0]  data_ch;
    logic        adc_convst;
    logic        adc_sck;
    logic        adc_sdi;
    logic        adc_sdo;

    ltc2308_spi_ctrl #(
        .CONV_CYCLES (CONV),
        .SCK_HALF    (HALF),
        .ACQ_CYCLES  (ACQ)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .ch         (ch),
        .uni        (uni),
        .busy       (busy),
        .data_valid (data_valid),
        .data       (data),
        .data_ch    (data_ch),
        .adc_convst (adc_convst),
        .adc_sck    (adc_sck),
        .adc_sdi    (adc_sdi),
        .adc_sdo    (adc_sdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC SDO model: CONVST rising restarts the bit pointer, each SCK fall
    // moves to the next lower bit, zeros after the LSB.
    logic [11:0] sdo_word;
    int          n_fall = 0;
    always @(negedge adc_sck or posedge adc_convst) begin
        if (adc_convst) n_fall = 0;
        else            n_fall = n_fall + 1;
    end
    assign adc_sdo = (n_fall < 12) ? sdo_word[11 - n_fall] : 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state
    bit          m_known;
    logic [2:0]  m_prev_ch;
    logic [11:0] m_data;
    logic [2:0]  m_ch;

    function automatic logic [5:0] cfg_word(input logic [2:0] c, input logic u);
        return {1'b1, c[0], c[2], c[1], u, 1'b0};
    endfunction

    task automatic model_reset();
        m_known   = 1'b0;
        m_prev_ch = 3'd0;
        m_data    = 12'h000;
        m_ch      = 3'd0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one complete frame starting at a negedge with busy low.
    task automatic run_frame(input string tag, input logic [2:0] fch, input logic funi,
                             input logic [11:0] word, input logic [5:0] exp_cfg,
                             input bit mid, input bit hold, output int acc);
        int          s, rises, first_rise, last_rise, gap_err, sck_hi, conv_cnt;
        int          valid_cnt, valid_at, extra;
        logic [11:0] sdi_bits, v_data;
        logic [2:0]  v_ch;
        logic        prev_sck;
        bit          exp_valid;

        ch = fch; uni = funi; sdo_word = word; start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        acc = cyc;
        check({tag, "_accept"}, busy, 1);

        s = 0; rises = 0; first_rise = -1; last_rise = 0; gap_err = 0; sck_hi = 0;
        conv_cnt = 0; valid_cnt = 0; valid_at = -1; sdi_bits = '0; v_data = '0;
        v_ch = '0; prev_sck = 1'b0;
        while (busy === 1'b1 && s < 300) begin
            if (mid) start = (s == 10 || s == 50 || s == 100);
            if (adc_convst) conv_cnt++;
            if (adc_sck) sck_hi++;
            if (adc_sck && !prev_sck) begin
                rises++;
                if (rises == 1) first_rise = s;
                else if (s - last_rise != 2 * HALF) gap_err++;
                last_rise = s;
                sdi_bits = {sdi_bits[10:0], adc_sdi};
            end
            prev_sck = adc_sck;
            if (data_valid) begin
                valid_cnt++;
                valid_at = s;
                v_data   = data;
                v_ch     = data_ch;
            end
            @(negedge clk);
            s++;
        end
        if (!hold) start = 1'b0;

        check({tag, "_busy_len"},   s,          BUSY_LEN);
        check({tag, "_convst_len"}, conv_cnt,   CONV);
        check({tag, "_sck_rises"},  rises,      12);
        check({tag, "_first_rise"}, first_rise, CONV + HALF);
        check({tag, "_sck_period"}, gap_err,    0);
        check({tag, "_sck_high"},   sck_hi,     12 * HALF);
        check({tag, "_sdi_bits"},   sdi_bits,   {exp_cfg, 6'b000000});

        exp_valid = m_known;
        if (m_known) begin
            m_data = word;
            m_ch   = m_prev_ch;
        end
        m_prev_ch = fch;
        m_known   = 1'b1;

        check({tag, "_valid_cnt"}, valid_cnt, exp_valid ? 1 : 0);
        if (exp_valid) begin
            check({tag, "_valid_at"},   valid_at, CONV + 24 * HALF);
            check({tag, "_valid_data"}, v_data,   m_data);
            check({tag, "_valid_ch"},   v_ch,     m_ch);
        end
        check({tag, "_data_hold"},    data,    m_data);
        check({tag, "_data_ch_hold"}, data_ch, m_ch);

        if (mid) begin
            extra = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (busy !== 1'b0) extra++;
            end
            check({tag, "_no_requeue"}, extra, 0);
        end
    endtask

    typedef struct {
        logic [2:0]  ch;
        logic        uni;
        logic [11:0] word;
        logic [5:0]  exp_cfg;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int acc, prev_acc, s, rises;
        logic prev;
        logic [2:0]  rch;
        logic        runi;
        logic [11:0] rword;

        tbl[0] = '{3'd3, 1'b1, 12'h3C3, 6'b110110};
        tbl[1] = '{3'd5, 1'b1, 12'hA5C, 6'b111010};
        tbl[2] = '{3'd0, 1'b0, 12'h001, 6'b100000};
        tbl[3] = '{3'd7, 1'b1, 12'h800, 6'b111110};
        tbl[4] = '{3'd2, 1'b0, 12'h6B9, 6'b100100};
        tbl[5] = '{3'd6, 1'b1, 12'h124, 6'b101110};
        tbl[6] = '{3'd4, 1'b0, 12'hFED, 6'b101000};
        tbl[7] = '{3'd1, 1'b1, 12'h555, 6'b110010};

        reset_n = 1'b0; start = 1'b0; ch = '0; uni = 1'b0; sdo_word = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_busy",   busy,       0);
        check("rst_valid",  data_valid, 0);
        check("rst_data",   data,       0);
        check("rst_dch",    data_ch,    0);
        check("rst_convst", adc_convst, 0);
        check("rst_sck",    adc_sck,    0);
        check("rst_sdi",    adc_sdi,    0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_frame($sformatf("tbl%0d", i), tbl[i].ch, tbl[i].uni, tbl[i].word,
                      tbl[i].exp_cfg, 1'b0, 1'b0, acc);

        run_frame("mid", 3'd6, 1'b0, 12'h5A5, 6'b101100, 1'b1, 1'b0, acc);

        // Reset during the 5th SCK high phase must clear outputs without a clock edge.
        ch = 3'd2; uni = 1'b1; sdo_word = 12'h777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = 0; rises = 0; prev = 1'b0;
        while (rises < 5 && s < 300) begin
            @(negedge clk);
            s++;
            if (adc_sck && !prev) rises++;
            prev = adc_sck;
        end
        check("mrst_reach", rises, 5);
        check("mrst_pre_sck", adc_sck, 1);
        check("mrst_pre_sdi", adc_sdi, 1);
        check("mrst_pre_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mrst_sck",    adc_sck,    0);
        check("mrst_convst", adc_convst, 0);
        check("mrst_sdi",    adc_sdi,    0);
        check("mrst_busy",   busy,       0);
        check("mrst_data",   data,       0);
        check("mrst_dch",    data_ch,    0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_frame("post_rst0", 3'd4, 1'b1, 12'h9C1, 6'b101010, 1'b0, 1'b0, acc);
        run_frame("post_rst1", 3'd3, 1'b0, 12'h2E7, 6'b110100, 1'b0, 1'b0, acc);

        // Back-to-back frames with start held high.
        do_reset();
        prev_acc = 0;
        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("hold%0d", i), 3'(i), 1'b0, 12'(12'h100 + i),
                      cfg_word(3'(i), 1'b0), 1'b0, 1'b1, acc);
            if (i > 0) check($sformatf("hold%0d_period", i), acc - prev_acc, BUSY_LEN + 1);
            prev_acc = acc;
        end
        start = 1'b0;
        @(negedge clk);

        run_frame("sdo_ones",  3'd7, 1'b0, 12'hFFF, 6'b111100, 1'b0, 1'b0, acc);
        run_frame("sdo_zeros", 3'd0, 1'b1, 12'h000, 6'b100010, 1'b0, 1'b0, acc);

        for (int i = 0; i < 10; i++) begin
            rch   = 3'($urandom_range(7, 0));
            runi  = 1'($urandom_range(1, 0));
            rword = 12'($urandom);
            run_frame($sformatf("rnd%0d", i), rch, runi, rword, cfg_word(rch, runi),
                      1'b0, 1'b0, acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ltc2308_spi_ctrl.md
Name: ltc2308_spi_ctrl

Overview:
Serial front-end for the board's LTC2308 8-channel 12-bit ADC. It drives CONVST/SCK/SDI, shifts in SDO, and presents each result as a 12-bit word with a valid pulse to the sampling/Avalon logic inside the system. One start request produces one conversion frame, and the channel/mode for the next conversion is programmed during the same frame. It runs from the 50 MHz system clock with the system active-low reset.

Parameters:
CONV_CYCLES, 80, clk cycles CONVST is held high (>= 1.6 us tCONV at 50 MHz)
SCK_HALF, 2, clk cycles per SCK half-period (default 12.5 MHz SCK)
ACQ_CYCLES, 12, clk cycles SCK/CONVST held low after last SCK before the frame ends (tACQ >= 240 ns)

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous, active-low reset
start  in  1  frame request; accepted only when busy=0
ch  in  3  single-ended channel for the NEXT conversion, sampled with start
uni  in  1  1 = unipolar, 0 = bipolar, sampled with start
busy  out  1  high from the cycle after acceptance until the frame ends
data_valid  out  1  one-cycle pulse; data/data_ch valid
data  out  12  conversion result, MSB first off SDO
data_ch  out  3  channel that produced data
adc_convst  out  1  to ADC_CONVST
adc_sck  out  1  to ADC_SCLK
adc_sdi  out  1  to ADC_DIN
adc_sdo  in  1  from ADC_DOUT

Behaviour:
- One clock, asynchronous active-low reset. All outputs are registered.
- Reset values: busy, data_valid, adc_convst, adc_sck and adc_sdi = 0; data = 0; data_ch = 0; cfg_known flag = 0; FSM = IDLE.
- Config word (6 bits, sent MSB first): {S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=uni, SLP=0}. With this mapping CH0=000, CH1=100, ..., CH7=111 in O/S,S1,S0.
- IDLE: when start=1, latch cfg, ch and uni, then go to CONV. busy rises on the next cycle.
- CONV: adc_convst=1 for exactly CONV_CYCLES cycles, then adc_convst=0 and go to SHIFT. adc_sdi presents cfg[5] from SHIFT entry.
- SHIFT: 12 SCK periods, each SCK_HALF cycles low followed by SCK_HALF cycles high, starting low.
  - On the clk edge that drives adc_sck 0->1, shift adc_sdo into the receive register (MSB first).
  - On the clk edge that drives adc_sck 1->0, advance adc_sdi to the next cfg bit. After the 6 cfg bits, adc_sdi=0.
  - After the 12th falling edge, adc_sck=0 and go to ACQ.
- ACQ: hold for ACQ_CYCLES cycles, then go to IDLE and drop busy.
  - On the first ACQ cycle, data is loaded from the receive register and data_ch from prev_ch.
  - In that same cycle, data_valid=1 only if cfg_known=1.
  - Then prev_ch is set to the latched ch and cfg_known is set to 1.
- The result of a frame belongs to the config sent in the previous frame, per the LTC2308 pipeline. The first frame after reset therefore produces no data_valid.
- busy length = CONV_CYCLES + 24*SCK_HALF + ACQ_CYCLES cycles (140 at defaults).
- start while busy=1 is ignored; it is not queued.
- A start on the first cycle busy=0 is accepted. With start held high continuously, frames repeat every 141 cycles at defaults.
- Reset mid-frame: all outputs clear asynchronously and cfg_known=0, so the next completed frame is discarded.
- data and data_ch hold their values until the next valid frame.
- Parameter values < 1 are illegal. Counter widths are derived with $clog2.

Test Plan:
- Reset, then start with ch=3, uni=1 -> busy high for 140 cycles; convst high 80 cycles; 12 SCK pulses with period 4 cycles; SDI bits 1,1,0,1,1,0 then zeros; no data_valid.
- Second frame with ch=5 and an SDO model returning 0xA5C -> one data_valid pulse with data=0xA5C, data_ch=3. SDI carries 1,1,1,0,1,0.
- Pulse start at cycles 10, 50 and 100 of a busy frame -> no extra frames; busy falls exactly 140 cycles after acceptance.
- Assert reset_n=0 during the 5th SCK high phase -> SCK, CONVST, SDI and busy go 0 without waiting for clk. The next frame gives no data_valid; the frame after gives data_valid.
- Hold start=1 for 5 frames with ch=0..4 -> frame period 141 cycles; valid pulses on frames 2..5 with data_ch = 0,1,2,3.
- SDO stuck at 1, then stuck at 0 -> data=0xFFF, then 0x000.
